pc_unit: RTL and testbench

Parametrised program counter for the pipelined core's fetch stage.
- Over plain load/hold it adds: sequential increment, branch redirect, trap vectoring, a pending-redirect latch that survives stalls and halts, a boot/halt state machine and a saturating flush counter.
- Sits at IF and drives the instruction-memory address.
- Inputs come from the hazard unit (stall), EX (redirect) and the exception logic (trap).

---
 rtl/pc_unit.sv | 177 +++++++++++++++++
 tb/tb_pc_unit.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Fetch-stage program counter: boot/run/halt control, latched pending redirects,
// trap vectoring and a saturating flush counter. Optional `PC_ALIGN_CHECK_EN adds misalign_err.
module pc_unit #(
    parameter int unsigned     PC_W      = 64,
    parameter int unsigned     STEP      = 4,
    parameter logic [PC_W-1:0] RESET_VEC = '0,
    parameter logic [PC_W-1:0] TRAP_VEC  = PC_W'(32'd256),
    parameter int unsigned     CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             redirect_valid,
    input  logic [PC_W-1:0]  redirect_pc,
    input  logic             trap_valid,
    input  logic             halt,
    input  logic             resume,
    output logic [PC_W-1:0]  pc_out,
    output logic             pc_valid,
    output logic             redirect_pending,
`ifdef PC_ALIGN_CHECK_EN
    output logic             misalign_err,
`endif
    output logic [CNT_W-1:0] flush_count
);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    localparam logic [PC_W-1:0]  STEP_V  = PC_W'(STEP);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef PC_ALIGN_CHECK_EN
    localparam logic [PC_W-1:0]  ALIGN_MASK = PC_W'(STEP - 1);
`endif

    state_t            state_q, state_d;
    logic [PC_W-1:0]   pc_q, pc_d;
    logic [PC_W-1:0]   tgt_q, tgt_d;
    logic              valid_q, valid_d;
    logic              pend_q, pend_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mis_q, mis_d;
    logic              trap_s, apply_s, inc_s;
    logic [PC_W-1:0]   apply_tgt_s;

    // Next-state: pick this cycle's event by state and priority, then resolve the PC load.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        valid_d     = valid_q;
        pend_d      = pend_q;
        mis_d       = 1'b0;
        trap_s      = 1'b0;
        apply_s     = 1'b0;
        inc_s       = 1'b0;
        apply_tgt_s = tgt_q;
        case (state_q)
            S_BOOT: begin
                state_d = S_RUN;
                valid_d = 1'b1;
                if (redirect_valid) begin
                    pend_d = 1'b1;
                    tgt_d  = redirect_pc;
                end else begin
                    pend_d = pend_q;
                end
            end
            S_RUN: begin
                valid_d = 1'b1;
                if (trap_valid) begin
                    trap_s = 1'b1;
                end else if (redirect_valid && !stall) begin
                    apply_s     = 1'b1;
                    apply_tgt_s = redirect_pc;
                end else if (redirect_valid) begin
                    pend_d = 1'b1;
                    tgt_d  = redirect_pc;
                end else if (pend_q && !stall) begin
                    apply_s = 1'b1;
                end else if (stall) begin
                    pc_d = pc_q;
                end else if (halt) begin
                    state_d = S_HALT;
                    valid_d = 1'b0;
                end else begin
                    pc_d = pc_q + STEP_V;
                end
            end
            S_HALT: begin
                valid_d = 1'b0;
                // A redirect arriving with resume is the youngest target and is applied directly.
                if (redirect_valid) begin
                    pend_d = 1'b1;
                    tgt_d  = redirect_pc;
                end else begin
                    pend_d = pend_q;
                end
                if (trap_valid) begin
                    trap_s  = 1'b1;
                    state_d = S_RUN;
                    valid_d = 1'b1;
                end else if (resume) begin
                    state_d     = S_RUN;
                    valid_d     = 1'b1;
                    apply_s     = pend_d;
                    apply_tgt_s = tgt_d;
                end else begin
                    state_d = S_HALT;
                end
            end
            default: begin
                state_d = S_BOOT;
                valid_d = 1'b0;
            end
        endcase

        if (trap_s) begin
            pc_d   = TRAP_VEC;
            pend_d = 1'b0;
            inc_s  = 1'b1;
        end else if (apply_s) begin
            pend_d = 1'b0;
            inc_s  = 1'b1;
`ifdef PC_ALIGN_CHECK_EN
            if ((apply_tgt_s & ALIGN_MASK) != '0) begin
                pc_d  = TRAP_VEC;
                mis_d = 1'b1;
            end else begin
                pc_d  = apply_tgt_s;
            end
`else
            pc_d = apply_tgt_s;
`endif
        end else begin
            inc_s = 1'b0;
        end

        cnt_d = (inc_s && (cnt_q != CNT_MAX)) ? cnt_q + CNT_W'(1) : cnt_q;
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_VEC;
            tgt_q   <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
        end
    end

    assign pc_out           = pc_q;
    assign pc_valid         = valid_q;
    assign redirect_pending = pend_q;
    assign flush_count      = cnt_q;
`ifdef PC_ALIGN_CHECK_EN
    assign misalign_err     = mis_q;
`else
    logic unused_s;
    assign unused_s = mis_q;
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: a 64-bit default instance and an 8-bit/CNT_W=2 instance
// share stimulus; a spec-level reference model feeds per-instance expectation queues.
module tb_pc_unit;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, stall, rv, tv, halt, resume;
    logic [63:0] rpc;

    logic [63:0] pc_o;
    logic        val_o, pend_o;
    logic [15:0] cnt_o;
    logic [7:0]  pc8_o;
    logic        val8_o, pend8_o;
    logic [1:0]  cnt8_o;
`ifdef PC_ALIGN_CHECK_EN
    logic        mis_o, mis8_o;
`endif

    pc_unit dut (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(rv), .redirect_pc(rpc),
        .trap_valid(tv), .halt(halt), .resume(resume), .pc_out(pc_o), .pc_valid(val_o),
        .redirect_pending(pend_o),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_err(mis_o),
`endif
        .flush_count(cnt_o)
    );

    pc_unit #(.PC_W(8), .STEP(4), .RESET_VEC(8'h00), .TRAP_VEC(8'h80), .CNT_W(2)) dut8 (
        .clk(clk), .reset(reset), .stall(stall), .redirect_valid(rv), .redirect_pc(rpc[7:0]),
        .trap_valid(tv), .halt(halt), .resume(resume), .pc_out(pc8_o), .pc_valid(val8_o),
        .redirect_pending(pend8_o),
`ifdef PC_ALIGN_CHECK_EN
        .misalign_err(mis8_o),
`endif
        .flush_count(cnt8_o)
    );

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] pc;
        logic [63:0] tgt;
        logic        valid;
        logic        pend;
        logic        mis;
        int          cnt;
        int          mode;   // 0 boot, 1 run, 2 halted
    } mst_t;

    mst_t m64, m8;
    mst_t q64[$];
    mst_t q8[$];

    function automatic mst_t model(mst_t s, int w, int stp, logic [63:0] rvec, logic [63:0] tvec,
                                   int cmax, logic rn, logic st_i, logic rv_i, logic [63:0] rpc_i,
                                   logic tv_i, logic h_i, logic rs_i);
        mst_t n = s;
        logic [63:0] msk = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        logic [63:0] t = 64'd0;
        bit hit = 1'b0;
        n.mis = 1'b0;
        if (!rn) begin
            n.pc = rvec; n.tgt = 64'd0; n.valid = 1'b0; n.pend = 1'b0; n.cnt = 0; n.mode = 0;
            return n;
        end
        rpc_i = rpc_i & msk;
        if (s.mode == 0) begin
            n.mode = 1; n.valid = 1'b1;
            if (rv_i) begin n.pend = 1'b1; n.tgt = rpc_i; end
        end else if (s.mode == 1) begin
            if (tv_i) begin n.pc = tvec; n.pend = 1'b0; n.cnt = n.cnt + 1; end
            else if (rv_i && !st_i) begin hit = 1'b1; t = rpc_i; end
            else if (rv_i) begin n.pend = 1'b1; n.tgt = rpc_i; end
            else if (s.pend && !st_i) begin hit = 1'b1; t = s.tgt; end
            else if (st_i) n.pc = s.pc;
            else if (h_i) begin n.mode = 2; n.valid = 1'b0; end
            else n.pc = (s.pc + 64'(stp)) & msk;
        end else begin
            if (rv_i) begin n.pend = 1'b1; n.tgt = rpc_i; end
            if (tv_i) begin
                n.pc = tvec; n.pend = 1'b0; n.cnt = n.cnt + 1; n.mode = 1; n.valid = 1'b1;
            end else if (rs_i) begin
                n.mode = 1; n.valid = 1'b1;
                if (n.pend) begin hit = 1'b1; t = n.tgt; end
            end
        end
        if (hit) begin
            n.pend = 1'b0;
            n.cnt  = n.cnt + 1;
            n.pc   = t;
`ifdef PC_ALIGN_CHECK_EN
            if ((t % 64'(stp)) != 64'd0) begin n.pc = tvec; n.mis = 1'b1; end
`endif
        end
        if (n.cnt > cmax) n.cnt = cmax;
        return n;
    endfunction

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: each edge the DUT presents a new output set; compare it with the queued expectation.
    always @(posedge clk) begin
        mst_t e;
        #1;
        if (q64.size() > 0) begin
            e = q64.pop_front();
            cmp("pc64", pc_o, e.pc);
            cmp("valid64", 64'(val_o), 64'(e.valid));
            cmp("pend64", 64'(pend_o), 64'(e.pend));
            cmp("cnt64", 64'(cnt_o), 64'(e.cnt));
`ifdef PC_ALIGN_CHECK_EN
            cmp("mis64", 64'(mis_o), 64'(e.mis));
`endif
        end
        if (q8.size() > 0) begin
            e = q8.pop_front();
            cmp("pc8", 64'(pc8_o), e.pc);
            cmp("valid8", 64'(val8_o), 64'(e.valid));
            cmp("pend8", 64'(pend8_o), 64'(e.pend));
            cmp("cnt8", 64'(cnt8_o), 64'(e.cnt));
`ifdef PC_ALIGN_CHECK_EN
            cmp("mis8", 64'(mis8_o), 64'(e.mis));
`endif
        end
    end

    task automatic cyc(input logic rn, input logic s, input logic r, input logic [63:0] p,
                       input logic t, input logic h, input logic rs);
        @(negedge clk);
        reset = rn; stall = s; rv = r; rpc = p; tv = t; halt = h; resume = rs;
        m64 = model(m64, 64, 4, 64'h0, 64'h100, 65535, rn, s, r, p, t, h, rs);
        q64.push_back(m64);
        m8 = model(m8, 8, 4, 64'h0, 64'h80, 3, rn, s, r, p, t, h, rs);
        q8.push_back(m8);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        cyc(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; rv = 1'b0; rpc = 64'h0; tv = 1'b0; halt = 1'b0; resume = 1'b0;

        // Reset and boot
        repeat (3) do_reset();
        settle();
        cmp("rst_pc", pc_o, 64'h0);
        cmp("rst_valid", 64'(val_o), 64'h0);
        idle(); settle();
        cmp("boot_pc", pc_o, 64'h0);
        cmp("boot_valid", 64'(val_o), 64'h1);
        repeat (3) idle();
        settle();
        cmp("seq_pc12", pc_o, 64'hC);

        // Redirect during stall
        repeat (5) idle();
        settle();
        cmp("run_pc20", pc_o, 64'h20);
        repeat (2) cyc(1'b1, 1'b1, 1'b1, 64'h400, 1'b0, 1'b0, 1'b0);
        settle();
        cmp("stall_pc", pc_o, 64'h20);
        cmp("stall_pend", 64'(pend_o), 64'h1);
        idle(); settle();
        cmp("applied_pc", pc_o, 64'h400);
        cmp("applied_cnt", 64'(cnt_o), 64'h1);
        idle(); settle();
        cmp("after_pc", pc_o, 64'h404);

        // Pending overwrite and trap priority
        do_reset(); idle();
        cyc(1'b1, 1'b1, 1'b1, 64'h400, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 64'h800, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0, 1'b0);
        settle();
        cmp("trap_pc", pc_o, 64'h100);
        cmp("trap_pend", 64'(pend_o), 64'h0);
        cmp("trap_cnt", 64'(cnt_o), 64'h1);
        cyc(1'b1, 1'b1, 1'b1, 64'h400, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 64'h800, 1'b0, 1'b0, 1'b0);
        idle(); settle();
        cmp("overwrite_pc", pc_o, 64'h800);

        // Halt and resume
        do_reset(); idle();
        repeat (4) idle();
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0);
        settle();
        cmp("halt_pc", pc_o, 64'h10);
        cmp("halt_valid", 64'(val_o), 64'h0);
        cyc(1'b1, 1'b0, 1'b1, 64'h200, 1'b0, 1'b0, 1'b0);
        settle();
        cmp("halt_pend", 64'(pend_o), 64'h1);
        cyc(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b1);
        settle();
        cmp("resume_pc", pc_o, 64'h200);
        cmp("resume_valid", 64'(val_o), 64'h1);
        cmp("resume_cnt", 64'(cnt_o), 64'h1);

        // Wrap and saturation on the narrow instance
        do_reset(); idle();
        cyc(1'b1, 1'b0, 1'b1, 64'hF8, 1'b0, 1'b0, 1'b0);
        idle(); settle();
        cmp("wrap_fc", 64'(pc8_o), 64'hFC);
        idle(); settle();
        cmp("wrap_00", 64'(pc8_o), 64'h00);
        idle(); settle();
        cmp("wrap_04", 64'(pc8_o), 64'h04);
        for (int i = 0; i < 5; i++) cyc(1'b1, 1'b0, 1'b1, 64'(16 * (i + 1)), 1'b0, 1'b0, 1'b0);
        settle();
        cmp("sat_cnt8", 64'(cnt8_o), 64'h3);
        cmp("cnt64_six", 64'(cnt_o), 64'h6);

`ifdef PC_ALIGN_CHECK_EN
        do_reset(); idle();
        cyc(1'b1, 1'b0, 1'b1, 64'h402, 1'b0, 1'b0, 1'b0);
        settle();
        cmp("mis_pc", pc_o, 64'h100);
        cmp("mis_pulse", 64'(mis_o), 64'h1);
        cyc(1'b1, 1'b0, 1'b1, 64'h404, 1'b0, 1'b0, 1'b0);
        settle();
        cmp("al_pc", pc_o, 64'h404);
        cmp("al_mis", 64'(mis_o), 64'h0);
`endif

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            logic [63:0] p;
            p = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) p[1:0] = 2'b00;
            if ($urandom_range(0, 3) == 0) p[63:8] = 56'h0;
            cyc($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 4) == 0,
                p, $urandom_range(0, 19) == 0, $urandom_range(0, 9) == 0,
                $urandom_range(0, 4) == 0);
        end
        idle();
        repeat (3) @(posedge clk);
        #2;
        if (q64.size() != 0 || q8.size() != 0) begin
            failures++;
            $display("FAIL drain: actual=%0d expected=0", q64.size() + q8.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
